control_word_sequencer: RTL

Consumer-side end of the decoder interface. It accepts fetched instructions, drives the instruction and micro-step state into the combinational decoders, and registers the returned {controlWord, nextState, K}. It then issues each micro-op to the datapath over a valid/ready handshake and steps through multi-cycle instructions until a decoder returns nextState = 0. It sits between instruction fetch and the datapath control inputs.

---
 rtl/control_word_sequencer_pkg.sv | 38 +++
 rtl/control_word_sequencer_cw_output_mask.sv | 21 ++
 rtl/control_word_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/control_word_sequencer_pkg.sv
// Shared definitions for the control-word sequencer: the field layout of the
// decoder control word, the datapath word widths and the sequencer FSM encoding.
package control_word_sequencer_pkg;

    localparam int CW_W = 31;
    localparam int K_W  = 64;

    // Control word layout, MSB first:
    // {Psel, DA, SA, SB, Fsel, regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}
    localparam int PSEL_LSB   = 29;
    localparam int PSEL_W     = 2;
    localparam int DA_LSB     = 24;
    localparam int DA_W       = 5;
    localparam int SA_LSB     = 19;
    localparam int SA_W       = 5;
    localparam int SB_LSB     = 14;
    localparam int SB_W       = 5;
    localparam int FSEL_LSB   = 9;
    localparam int FSEL_W     = 5;
    localparam int REGW_BIT   = 8;
    localparam int RAMW_BIT   = 7;
    localparam int EN_MEM_BIT = 6;
    localparam int EN_ALU_BIT = 5;
    localparam int EN_B_BIT   = 4;
    localparam int EN_PC_BIT  = 3;
    localparam int BSEL_BIT   = 2;
    localparam int PCSEL_BIT  = 1;
    localparam int SL_BIT     = 0;

    localparam logic [PSEL_W-1:0] PSEL_HOLD = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/control_word_sequencer_cw_output_mask.sv
// Turns an idle control word into a harmless bubble: PC held, no register,
// memory or PC writes. A live word passes through untouched.
module cw_output_mask
    import control_word_sequencer_pkg::*;
(
    input  logic [CW_W-1:0] cw_in,
    input  logic            cw_valid,
    output logic [CW_W-1:0] cw_out
);

    always_comb begin
        cw_out = cw_in;
        if (!cw_valid) begin
            cw_out[PSEL_LSB +: PSEL_W] = PSEL_HOLD;
            cw_out[REGW_BIT]           = 1'b0;
            cw_out[RAMW_BIT]           = 1'b0;
            cw_out[EN_PC_BIT]          = 1'b0;
        end
    end

endmodule

// File: rtl/control_word_sequencer.sv
// Sequences fetched instructions through the combinational decoders and issues
// one registered micro-op at a time to the datapath over valid/ready.
module control_word_sequencer
    import control_word_sequencer_pkg::*;
#(
    parameter int MAX_STEPS = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [31:0]      dec_instruction,
    output logic [1:0]       dec_state,
    input  logic [30:0]      dec_control_word,
    input  logic [1:0]       dec_next_state,
    input  logic [63:0]      dec_k,
    output logic [30:0]      cw_out,
    output logic [63:0]      k_out,
    output logic             cw_valid,
    input  logic             cw_ready,
    input  logic             flush,
    output logic             seq_err,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [2:0] STEP_LIMIT = 3'(MAX_STEPS);

    seq_state_e       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [1:0]       step_q, step_d;
    logic [CW_W-1:0]  cw_q, cw_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [1:0]       next_q, next_d;
    logic [2:0]       steps_done_q, steps_done_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] issue_count_q, issue_count_d;

    // Ready is forced low while reset is held so fetch never sees a handshake
    // against a sequencer that cannot capture it.
    assign instr_ready     = (state_q == ST_IDLE) && reset;
    assign cw_valid        = (state_q == ST_ISSUE);
    assign dec_instruction = ir_q;
    assign dec_state       = step_q;
    assign k_out           = k_q;
    assign seq_err         = seq_err_q;
    assign issue_count     = issue_count_q;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case can infer a latch.
        state_d       = state_q;
        ir_d          = ir_q;
        step_d        = step_q;
        cw_d          = cw_q;
        k_d           = k_q;
        next_d        = next_q;
        steps_done_d  = steps_done_q;
        seq_err_d     = seq_err_q;
        issue_count_d = issue_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ir_d         = instr;
                    step_d       = 2'd0;
                    steps_done_d = 3'd0;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cw_d    = dec_control_word;
                    k_d     = dec_k;
                    next_d  = dec_next_state;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An accept that coincides with flush still reached the datapath.
                if (cw_ready) begin
                    issue_count_d = issue_count_q + 1'b1;
                    steps_done_d  = steps_done_q + 3'd1;
                end
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cw_ready) begin
                    if (next_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else if (steps_done_q + 3'd1 == STEP_LIMIT) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        step_d  = next_q;
                        state_d = ST_DECODE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ir_q          <= '0;
            step_q        <= '0;
            cw_q          <= '0;
            k_q           <= '0;
            next_q        <= '0;
            steps_done_q  <= '0;
            seq_err_q     <= 1'b0;
            issue_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q       <= state_d;
            ir_q          <= ir_d;
            step_q        <= step_d;
            cw_q          <= cw_d;
            k_q           <= k_d;
            next_q        <= next_d;
            steps_done_q  <= steps_done_d;
            seq_err_q     <= seq_err_d;
            issue_count_q <= issue_count_d;
        end
    end

    cw_output_mask u_cw_output_mask (
        .cw_in    (cw_q),
        .cw_valid (cw_valid),
        .cw_out   (cw_out)
    );

endmodule
